// File: rtl/uart_reader.sv
// uart_reader: UART receive path (8N1) with sticky overrun/frame-error flags for an HPS PIO.
// Define UART_READER_PARITY_EN to select 8E1 framing with an even-parity check.
module uart_reader #(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    input  logic       rd_ack,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       overrun,
    output logic       frame_err,
    output logic       busy
);
    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned TW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] BIT_LAST   = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST  = TW'(HALF_BIT - 1);

`ifdef UART_READER_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state_q;
    logic [TW-1:0] timer_q;
    logic [2:0]    bit_idx_q;
    logic          rx_meta_q;
    logic          rx_sync_q;
    logic          rx_prev_q;
    logic [7:0]    shift_q;
    logic [7:0]    rx_data_q;
    logic          rx_ready_q;
    logic          overrun_q;
    logic          frame_err_q;
    logic          busy_q;
    logic          stop_done_q;
    logic          stop_good_c;

`ifdef UART_READER_PARITY_EN
    logic          parity_q;
    assign stop_good_c = rx_sync_q && ((^shift_q) == parity_q);
`else
    assign stop_good_c = rx_sync_q;
`endif

    // Edge detection needs the previous synced level, so a line stuck low never re-triggers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            bit_idx_q   <= '0;
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_ready_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
            stop_done_q <= 1'b0;
`ifdef UART_READER_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q <= rx_in;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;

            if (rd_ack) begin
                rx_ready_q  <= 1'b0;
                overrun_q   <= 1'b0;
                frame_err_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    timer_q   <= '0;
                    bit_idx_q <= '0;
                    if (rx_prev_q && !rx_sync_q) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (timer_q == HALF_LAST) begin
                        timer_q <= '0;
                        if (rx_sync_q) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= DATA;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                DATA: begin
                    if (timer_q == BIT_LAST) begin
                        timer_q   <= '0;
                        shift_q   <= {rx_sync_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_READER_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
`ifdef UART_READER_PARITY_EN
                PARITY: begin
                    if (timer_q == BIT_LAST) begin
                        timer_q  <= '0;
                        parity_q <= rx_sync_q;
                        state_q  <= STOP;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
`endif
                STOP: begin
                    // Result lands on the sample edge; state leaves STOP one cycle later.
                    if (stop_done_q) begin
                        stop_done_q <= 1'b0;
                        timer_q     <= '0;
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                    end else if (timer_q == BIT_LAST) begin
                        stop_done_q <= 1'b1;
                        if (stop_good_c) begin
                            rx_data_q  <= shift_q;
                            rx_ready_q <= 1'b1;
                            overrun_q  <= rx_ready_q && !rd_ack;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_ready  = rx_ready_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_uart_reader.sv
// Bench for uart_reader: drives serial frames and checks outputs against a frame-level model.
module tb_uart_reader;
    localparam int unsigned CLK_FREQ = 50000000;
    localparam int unsigned BAUD     = 115200;
    localparam int CPB  = int'(CLK_FREQ / BAUD);
    localparam int HALF = CPB / 2;
`ifdef UART_READER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int NBITS = PAR ? 11 : 10;
    // Ideal stop-bit centre plus the two-flop input latency, counted from the start edge.
    localparam int TS = (NBITS - 1) * CPB + HALF + 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_in;
    logic       rd_ack;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       overrun;
    logic       frame_err;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int hold_until = 0;

    logic [7:0] exp_data;
    logic       exp_ready, exp_ovr, exp_ferr, exp_busy;

    uart_reader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .rd_ack(rd_ack),
        .rx_data(rx_data), .rx_ready(rx_ready), .overrun(overrun),
        .frame_err(frame_err), .busy(busy)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Every cycle outside the transition windows must match the model exactly.
    always @(negedge clk) begin
        if (cyc >= hold_until) begin
            n_tests++;
            if ({busy, frame_err, overrun, rx_ready, rx_data} !==
                {exp_busy, exp_ferr, exp_ovr, exp_ready, exp_data}) begin
                n_fail++;
                $display("FAIL cycle_compare @%0d: got busy=%b ferr=%b ovr=%b rdy=%b data=%02h, need busy=%b ferr=%b ovr=%b rdy=%b data=%02h",
                         cyc, busy, frame_err, overrun, rx_ready, rx_data,
                         exp_busy, exp_ferr, exp_ovr, exp_ready, exp_data);
            end
        end
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] need);
        n_tests++;
        if (act !== need) begin
            n_fail++;
            $display("FAIL %s: got %0h, need %0h", name, act, need);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        tick(n);
    endtask

    function automatic logic epar(input logic [7:0] b);
        return ^b;
    endfunction

    function automatic void model_reset();
        exp_data = 8'h00; exp_ready = 1'b0; exp_ovr = 1'b0; exp_ferr = 1'b0; exp_busy = 1'b0;
    endfunction

    function automatic void model_ack();
        exp_ready = 1'b0; exp_ovr = 1'b0; exp_ferr = 1'b0;
    endfunction

    function automatic void model_frame(input logic [7:0] b, input logic par_bit, input logic stop_bit);
        if (stop_bit && (!PAR || ((^b) == par_bit))) begin
            exp_ovr   = exp_ovr | exp_ready;
            exp_ready = 1'b1;
            exp_data  = b;
        end else begin
            exp_ferr = 1'b1;
        end
        exp_busy = 1'b0;
    endfunction

    // One frame, cycle by cycle; optional rd_ack pulse and mid-frame reset at given offsets.
    task automatic send_frame(input logic [7:0] b, input logic par_bit, input logic stop_bit,
                              input int ack_at, input int abort_at,
                              output int rise_c, output int fall_c);
        logic [10:0] bits;
        logic        prev_rdy, prev_busy;
        bit          coincide;
        bits[0]    = 1'b0;
        bits[8:1]  = b;
        bits[9]    = PAR ? par_bit : stop_bit;
        bits[10]   = stop_bit;
        coincide   = (ack_at >= TS - 6) && (ack_at <= TS + 6);
        rise_c = -1;
        fall_c = -1;
        for (int c = 0; c < NBITS * CPB; c++) begin
            if (c == abort_at) begin
                rst_n = 1'b0;
                rx_in = 1'b1;
                model_reset();
                return;
            end
            rx_in = bits[4'(c / CPB)];
            if (c == 0) begin
                exp_busy   = 1'b1;
                hold_until = cyc + 8;
            end
            if (c == ack_at) rd_ack = 1'b1;
            if (ack_at >= 0 && c == ack_at + 1) begin
                rd_ack = 1'b0;
                if (!coincide) model_ack();
            end
            if (c == TS - 6) hold_until = cyc + 14;
            if (c == TS) begin
                if (coincide) model_ack();
                model_frame(b, par_bit, stop_bit);
            end
            prev_rdy  = rx_ready;
            prev_busy = busy;
            tick(1);
            if (rise_c < 0 && rx_ready && !prev_rdy) rise_c = c;
            if (fall_c < 0 && prev_busy && !busy) fall_c = c;
        end
        rd_ack = 1'b0;
    endtask

    task automatic glitch(input int n);
        exp_busy   = 1'b1;
        hold_until = cyc + 8;
        for (int c = 0; c < CPB; c++) begin
            rx_in = (c < n) ? 1'b0 : 1'b1;
            if (c == HALF + 2 - 6) hold_until = cyc + 14;
            if (c == HALF + 2) exp_busy = 1'b0;
            tick(1);
        end
    endtask

    task automatic ack();
        rd_ack = 1'b1;
        tick(1);
        rd_ack = 1'b0;
        model_ack();
    endtask

    task automatic check_outputs(input string tag, input logic [7:0] d, input logic r,
                                 input logic o, input logic fe, input logic bz);
        check({tag, "_data"}, 32'(rx_data), 32'(d));
        check({tag, "_ready"}, 32'(rx_ready), 32'(r));
        check({tag, "_ovr"}, 32'(overrun), 32'(o));
        check({tag, "_ferr"}, 32'(frame_err), 32'(fe));
        check({tag, "_busy"}, 32'(busy), 32'(bz));
    endtask

    initial begin
        int r, f, lat;
        rst_n = 1'b0; rx_in = 1'b1; rd_ack = 1'b0;
        model_reset();
        tick(5);
        check_outputs("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        idle(20);

        // Bad stop bit right after reset: data stays 0x00.
        send_frame(8'h55, epar(8'h55), 1'b0, -1, -1, r, f);
        idle(30);
        check_outputs("badstop", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        ack();
        check("badstop_ack_ferr", 32'(frame_err), 32'd0);
        idle(30);

        // Latency of a clean frame and busy falling one cycle after rx_ready.
        send_frame(8'hA5, epar(8'hA5), 1'b1, -1, -1, r, f);
        lat = r;
        check("a5_data", 32'(rx_data), 32'hA5);
        check("a5_latency_in_window", 32'((r >= 4120) && (r <= 4130)), 32'd1);
        check("a5_busy_fall_after_ready", 32'(f - r), 32'd1);
        idle(30);
        ack();
        idle(30);

        // Two frames without acknowledge -> overrun, newest byte kept.
        send_frame(8'h3C, epar(8'h3C), 1'b1, -1, -1, r, f);
        idle(30);
        send_frame(8'hC3, epar(8'hC3), 1'b1, -1, -1, r, f);
        idle(30);
        check_outputs("overrun", 8'hC3, 1'b1, 1'b1, 1'b0, 1'b0);
        ack();
        check_outputs("overrun_ack", 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(30);

        // 100-cycle low glitch is rejected; following frame still decodes.
        glitch(100);
        idle(30);
        check_outputs("glitch", 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h81, epar(8'h81), 1'b1, -1, -1, r, f);
        idle(30);
        check_outputs("after_glitch", 8'h81, 1'b1, 1'b0, 1'b0, 1'b0);

        // rd_ack mid-frame clears the old byte without disturbing reception.
        send_frame(8'h5A, epar(8'h5A), 1'b1, 2000, -1, r, f);
        idle(30);
        check_outputs("ack_busy", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);

        // rd_ack on the very edge the frame completes: set wins, no overrun.
        send_frame(8'h99, epar(8'h99), 1'b1, lat, -1, r, f);
        idle(30);
        check_outputs("ack_coincide", 8'h99, 1'b1, 1'b0, 1'b0, 1'b0);
        ack();
        idle(30);

        // Break: line held low well past one frame -> exactly one frame error.
        send_frame(8'h00, 1'b0, 1'b0, -1, -1, r, f);
        rx_in = 1'b0;
        tick(3 * CPB);
        idle(30);
        check_outputs("break", 8'h99, 1'b0, 1'b0, 1'b1, 1'b0);
        ack();
        idle(30);

        // Reset in the middle of bit 4 of 0xFF abandons the frame.
        send_frame(8'hFF, epar(8'hFF), 1'b1, -1, 5 * CPB + HALF, r, f);
        tick(5);
        check_outputs("midreset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        idle(2 * CPB);
        check_outputs("midreset_release", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h12, epar(8'h12), 1'b1, -1, -1, r, f);
        idle(30);
        check_outputs("after_reset", 8'h12, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef UART_READER_PARITY_EN
        ack();
        idle(30);
        send_frame(8'h07, 1'b0, 1'b1, -1, -1, r, f);
        idle(30);
        check_outputs("par_bad", 8'h12, 1'b0, 1'b0, 1'b1, 1'b0);
        ack();
        idle(30);
        send_frame(8'h07, 1'b1, 1'b1, -1, -1, r, f);
        idle(30);
        check_outputs("par_good", 8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_reader.md
UART_READER -- requirements
Module: uart_reader

Interface
REQ-001 Parameter CLK_FREQ, 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, 115200, serial bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, 434 at defaults).
REQ-003 clk  input  1  system clock (FPGA_CLK1_50 domain); all logic rising-edge.
REQ-004 rst_n  input  1  reset: asynchronous, active-low (driven from hps_fpga_reset_n).
REQ-005 rx_in  input  1  serial line from GPIO pin, idle high, asynchronous to clk.
REQ-006 rd_ack  input  1  one-cycle pulse from HPS PIO: byte consumed, clear flags.
REQ-007 rx_data  output  8  last good received byte, held until next good frame.
REQ-008 rx_ready  output  1  unread byte present in rx_data.
REQ-009 overrun  output  1  sticky: good frame arrived while rx_ready=1.
REQ-010 frame_err  output  1  sticky: bad stop bit (or parity, when enabled).
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 rx_in SHALL pass a 2-flop synchronizer; all decisions use the synchronized value (2-cycle input latency).
REQ-013 States SHALL be IDLE, START, DATA, PARITY (macro only), STOP; one bit-timer counter (0..CLKS_PER_BIT-1) and a 3-bit bit index.
REQ-014 IDLE -> START on synchronized rx high-to-low transition; timer cleared.
REQ-015 START: after CLKS_PER_BIT/2 cycles sample; 0 -> DATA with timer cleared; 1 -> IDLE (glitch rejected, no flag change).
REQ-016 DATA: every CLKS_PER_BIT cycles sample one bit into a shift register, LSB first; after bit index 7 -> PARITY (macro) or STOP.
REQ-017 STOP: after CLKS_PER_BIT cycles sample; result applied on that same clock edge; -> IDLE next cycle.
REQ-018 Good stop (1): rx_data <= shift register; rx_ready <= 1; overrun <= 1 if rx_ready was already 1 (new byte overwrites old).
REQ-019 Bad stop (0): rx_data and rx_ready unchanged; frame_err <= 1; return to IDLE and wait for line high before accepting next start edge.
REQ-020 rd_ack SHALL clear rx_ready, overrun and frame_err on the next edge.
REQ-021 rd_ack coinciding with a good-frame update: set wins (rx_ready=1, rx_data new, overrun=0 since previous byte was acknowledged).
REQ-022 rd_ack while busy SHALL NOT disturb reception in progress.
REQ-023 Line held low (break): exactly one frame_err, no further frames until line returns high.

Reset
REQ-024 While rst_n=0: state IDLE, timer/index 0, synchronizer flops 1, rx_data 0x00, rx_ready 0, overrun 0, frame_err 0, busy 0.
REQ-025 Reset asserted mid-frame SHALL abandon the frame; after release a new start edge is required.

Configuration
REQ-026 Macro UART_READER_PARITY_EN defined: 8E1 framing; PARITY state samples one bit after data; mismatch vs even parity of the byte treated as bad frame (REQ-019 behaviour) after the stop bit is timed.
REQ-027 Macro undefined: 8N1 framing; PARITY state and logic absent; STOP follows bit index 7 directly.

Verification
REQ-028 8N1 byte 0xA5 at 115200 -> rx_data=0xA5, rx_ready=1 at ~9.5*434+2 cycles after start edge; busy low one cycle later.
REQ-029 Two frames 0x3C then 0xC3, no rd_ack -> rx_data=0xC3, rx_ready=1, overrun=1; rd_ack pulse -> all flags 0, rx_data stays 0xC3.
REQ-030 Frame 0x55 with stop bit 0 -> frame_err=1, rx_ready stays 0, rx_data unchanged (0x00 after reset).
REQ-031 100-cycle low glitch on idle line -> back to IDLE, no flag change; following 0x81 frame received correctly.
REQ-032 rst_n pulsed low at bit 4 of 0xFF -> all outputs reset values; subsequent 0x12 received correctly.
REQ-033 With UART_READER_PARITY_EN: 0x07 with parity 1 -> rx_ready=1; 0x07 with parity 0 -> frame_err=1, rx_data unchanged.
